// File: rtl/tpum_pkg.sv
// Shared types and constants for the TPUM XBOX port arbiter.
package tpum_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'b0001,
    ST_ISSUE    = 4'b0010,
    ST_WAIT_RSP = 4'b0100,
    ST_DONE     = 4'b1000
  } xbox_arb_state_t;

  localparam int unsigned REQ_A = 32'd0;
  localparam int unsigned REQ_B = 32'd1;
  localparam int unsigned REQ_C = 32'd2;

  // Round-robin successor of a requester index, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    if (idx + 32'd1 >= n) begin
      return 32'd0;
    end else begin
      return idx + 32'd1;
    end
  endfunction

endpackage

// File: rtl/tpum_rr_pick.sv
// Combinational round-robin selector: first requester at or above the
// pointer, scanning upward and wrapping.
module tpum_rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_rr_ptr,
  output logic [NUM_REQ-1:0] o_winner_oh,
  output logic [PTR_W-1:0]   o_winner_idx
);

  logic             w_found;
  logic [PTR_W-1:0] w_sel;

  // Scan NUM_REQ positions starting at the pointer; the first set request wins.
  always_comb begin
    w_found      = 1'b0;
    w_sel        = '0;
    o_winner_oh  = '0;
    o_winner_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sel = PTR_W'((int'(i_rr_ptr) + i) % NUM_REQ);
      if (!w_found && i_req[w_sel]) begin
        o_winner_oh[w_sel] = 1'b1;
        o_winner_idx       = w_sel;
        w_found            = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
  end

endmodule

// File: rtl/tpum_xbox_port_arbiter.sv
// Round-robin arbiter sharing the single XBOX memory port between the
// operand-A/B loaders and the result-C writer, with a read-response watchdog.
module tpum_xbox_port_arbiter
  import tpum_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 1024,
  parameter int TIMEOUT = 255
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ-1:0]        i_req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_wdata,
  output logic [NUM_REQ-1:0]        o_gnt,
  output logic [NUM_REQ-1:0]        o_done,
  output logic [DATA_W-1:0]         o_rd_data,
  output logic                      o_busy,
  output logic                      o_timeout_err,
  input  logic                      i_err_clear,
  output logic                      o_xbox_req_valid,
  input  logic                      i_xbox_req_ready,
  output logic                      o_xbox_we,
  output logic [ADDR_W-1:0]         o_xbox_addr,
  output logic [DATA_W-1:0]         o_xbox_wdata,
  input  logic                      i_xbox_rsp_valid,
  input  logic [DATA_W-1:0]         i_xbox_rsp_data
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMR_W = 16;
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT - 1);

  xbox_arb_state_t     r_state;
  xbox_arb_state_t     w_next_state;
  logic [PTR_W-1:0]    r_rr_ptr;
  logic [PTR_W-1:0]    r_owner;
  logic [NUM_REQ-1:0]  r_gnt;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rd_data;
  logic [TMR_W-1:0]    r_timer;
  logic                r_err;

  logic [NUM_REQ-1:0]  w_win_oh;
  logic [PTR_W-1:0]    w_win_idx;
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic                w_tmo_hit;
  logic                w_err_set;
  logic                w_valid;
  logic                w_busy;
  logic [NUM_REQ-1:0]  w_done;

  tpum_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .i_req        (i_req),
    .i_rr_ptr     (r_rr_ptr),
    .o_winner_oh  (w_win_oh),
    .o_winner_idx (w_win_idx)
  );

  // AND-OR mux of the winning requester's transaction fields.
  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sel_we    = w_sel_we | (w_win_oh[i] & i_req_we[i]);
      w_sel_addr  = w_sel_addr | ({ADDR_W{w_win_oh[i]}} & i_req_addr[i*ADDR_W +: ADDR_W]);
      w_sel_wdata = w_sel_wdata | ({DATA_W{w_win_oh[i]}} & i_req_wdata[i*DATA_W +: DATA_W]);
    end
  end

  assign w_tmo_hit = (r_timer == TMO_LAST);
  // A response landing on the timeout cycle takes precedence over the error.
  assign w_err_set = (r_state == ST_WAIT_RSP) && !i_xbox_rsp_valid && w_tmo_hit;

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (|i_req) begin
          w_next_state = ST_ISSUE;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (i_xbox_req_ready) begin
          w_next_state = r_we ? ST_DONE : ST_WAIT_RSP;
        end else begin
          w_next_state = ST_ISSUE;
        end
      end
      ST_WAIT_RSP: begin
        if (i_xbox_rsp_valid || w_tmo_hit) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_WAIT_RSP;
        end
      end
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // FSM output decode from the state register.
  always_comb begin
    w_valid = 1'b0;
    w_busy  = 1'b1;
    w_done  = '0;
    case (r_state)
      ST_IDLE:     w_busy  = 1'b0;
      ST_ISSUE:    w_valid = 1'b1;
      ST_WAIT_RSP: w_valid = 1'b0;
      ST_DONE:     w_done  = r_gnt;
      default:     w_busy  = 1'b0;
    endcase
  end

  // Transaction datapath: latch, watchdog timer, read capture, pointer advance.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rr_ptr  <= PTR_W'(REQ_A);
      r_owner   <= '0;
      r_gnt     <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rd_data <= '0;
      r_timer   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|i_req) begin
            r_owner <= w_win_idx;
            r_gnt   <= w_win_oh;
            r_we    <= w_sel_we;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
          end
        end
        ST_ISSUE: begin
          if (i_xbox_req_ready && !r_we) begin
            r_timer <= '0;
          end
        end
        ST_WAIT_RSP: begin
          if (i_xbox_rsp_valid) begin
            r_rd_data <= i_xbox_rsp_data;
          end else if (w_tmo_hit) begin
            r_rd_data <= '0;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        ST_DONE: begin
          r_gnt    <= '0;
          r_rr_ptr <= PTR_W'(rr_next(32'(r_owner), NUM_REQ));
        end
        default: r_gnt <= '0;
      endcase
    end
  end

  // Sticky watchdog error; a new timeout beats a simultaneous clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end else if (i_err_clear) begin
      r_err <= 1'b0;
    end
  end

  assign o_gnt            = r_gnt;
  assign o_done           = w_done;
  assign o_rd_data        = r_rd_data;
  assign o_busy           = w_busy;
  assign o_timeout_err    = r_err;
  assign o_xbox_req_valid = w_valid;
  assign o_xbox_we        = r_we;
  assign o_xbox_addr      = r_addr;
  assign o_xbox_wdata     = r_wdata;

endmodule

// File: tb/tb_tpum_xbox_port_arbiter.sv
// Self-checking bench for tpum_xbox_port_arbiter: vector table, directed
// corner sequences and a randomized run against a transaction-level model.
module tb_tpum_xbox_port_arbiter;
  import tpum_pkg::*;

  localparam int NR  = 3;
  localparam int AW  = 32;
  localparam int DW  = 1024;
  localparam int TMO = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req;
  logic [NR-1:0]   req_we;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]   gnt;
  logic [NR-1:0]   done;
  logic [DW-1:0]   rd_data;
  logic            busy;
  logic            timeout_err;
  logic            err_clear;
  logic            xbox_req_valid;
  logic            xbox_req_ready;
  logic            xbox_we;
  logic [AW-1:0]   xbox_addr;
  logic [DW-1:0]   xbox_wdata;
  logic            xbox_rsp_valid;
  logic [DW-1:0]   xbox_rsp_data;

  logic            f_we    [NR];
  logic [AW-1:0]   f_addr  [NR];
  logic [DW-1:0]   f_wdata [NR];

  int n_tests = 0;
  int n_fail  = 0;

  int             m_ptr;
  logic           m_err;
  logic [DW-1:0]  m_rd;

  typedef struct {
    logic [2:0]  mask;
    logic        we;
    int          rdy;
    int          rsp;
    logic [31:0] word;
    int          ew;
    int          elat;
    logic        eerr;
    logic [31:0] erd;
  } vec_t;

  vec_t tbl [9];

  tpum_xbox_port_arbiter #(
    .NUM_REQ (NR),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TMO)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_req            (req),
    .i_req_we         (req_we),
    .i_req_addr       (req_addr),
    .i_req_wdata      (req_wdata),
    .o_gnt            (gnt),
    .o_done           (done),
    .o_rd_data        (rd_data),
    .o_busy           (busy),
    .o_timeout_err    (timeout_err),
    .i_err_clear      (err_clear),
    .o_xbox_req_valid (xbox_req_valid),
    .i_xbox_req_ready (xbox_req_ready),
    .o_xbox_we        (xbox_we),
    .o_xbox_addr      (xbox_addr),
    .o_xbox_wdata     (xbox_wdata),
    .i_xbox_rsp_valid (xbox_rsp_valid),
    .i_xbox_rsp_data  (xbox_rsp_data)
  );

  always #5 clk = ~clk;

  // Pack per-requester fields onto the DUT buses.
  always_comb begin
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < NR; i++) begin
      req_we[i]               = f_we[i];
      req_addr[i*AW +: AW]    = f_addr[i];
      req_wdata[i*DW +: DW]   = f_wdata[i];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got ...%016h expected ...%016h", nm, act[63:0], exp[63:0]);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Acts as the XBOX for one transaction and checks it end to end.
  // Entry: #1 after an edge, DUT idle, req already driven. Exit: same point,
  // one cycle after done, winner's req dropped.
  task automatic serve(input string tag, input int rdy, input int rsp,
                       input logic [DW-1:0] rdat, input int ew, input int elat,
                       input logic eerr, input logic [DW-1:0] erd);
    int c    = 0;
    int vcnt = 0;
    int hs   = 0;
    bit got  = 0;
    while (!got && c < 100) begin
      tick();
      c++;
      if (xbox_req_valid) begin
        vcnt++;
        xbox_req_ready = (vcnt > rdy);
        if (xbox_req_ready) hs = c + 1;
        chk($sformatf("%s.addr", tag), xbox_addr, f_addr[ew]);
        chk($sformatf("%s.we", tag), xbox_we, f_we[ew]);
        chkw($sformatf("%s.wdata", tag), xbox_wdata, f_wdata[ew]);
      end else begin
        xbox_req_ready = 1'b0;
      end
      if (hs > 0 && c >= hs && rsp > 0 && (c - hs + 1) == rsp) begin
        xbox_rsp_valid = 1'b1;
        xbox_rsp_data  = rdat;
      end else begin
        xbox_rsp_valid = 1'b0;
        xbox_rsp_data  = ~rdat;
      end
      if (c == 1) chk($sformatf("%s.gnt", tag), gnt, 64'd1 << ew);
      if (done != '0) begin
        got = 1;
        chk($sformatf("%s.done", tag), done, 64'd1 << ew);
        chk($sformatf("%s.gnt_done", tag), gnt, 64'd1 << ew);
        chk($sformatf("%s.lat", tag), c, elat);
        chk($sformatf("%s.err", tag), timeout_err, eerr);
        chkw($sformatf("%s.rd", tag), rd_data, erd);
      end
    end
    chk($sformatf("%s.done_seen", tag), got, 1);
    req[ew]        = 1'b0;
    xbox_req_ready = 1'b0;
    tick();
    xbox_rsp_valid = 1'b0;
    chk($sformatf("%s.idle", tag), {gnt, done, busy}, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] dat;
    int order [5];
    rst = 1'b1;
    req = '0;
    err_clear = 1'b0;
    xbox_req_ready = 1'b0;
    xbox_rsp_valid = 1'b0;
    xbox_rsp_data  = '0;
    for (int i = 0; i < NR; i++) begin
      f_we[i]    = 1'b0;
      f_addr[i]  = 32'h100 + 32'h1000 * i;
      f_wdata[i] = rand_data();
    end
    f_wdata[REQ_C] = 1024'h1234;

    repeat (3) tick();
    chk("reset.outs", {gnt, done, busy, xbox_req_valid, timeout_err, xbox_we}, 0);
    chk("reset.addr", xbox_addr, 0);
    chkw("reset.rd", rd_data, '0);
    rst = 1'b0;
    tick();

    tbl[0] = '{3'b001, 1'b0, 0, 2, 32'hA5A5A5A5, 0, 4,  1'b0, 32'hA5A5A5A5};
    tbl[1] = '{3'b100, 1'b1, 5, 0, 32'h00000000, 2, 7,  1'b0, 32'hA5A5A5A5};
    tbl[2] = '{3'b111, 1'b0, 0, 1, 32'h3C3C3C3C, 0, 3,  1'b0, 32'h3C3C3C3C};
    tbl[3] = '{3'b101, 1'b0, 1, 3, 32'h5A5A5A5A, 2, 6,  1'b0, 32'h5A5A5A5A};
    tbl[4] = '{3'b110, 1'b1, 0, 0, 32'h00000000, 1, 2,  1'b0, 32'h5A5A5A5A};
    tbl[5] = '{3'b011, 1'b0, 0, 8, 32'h77777777, 0, 10, 1'b0, 32'h77777777};
    tbl[6] = '{3'b010, 1'b0, 2, 0, 32'h00000000, 1, 12, 1'b1, 32'h00000000};
    tbl[7] = '{3'b001, 1'b0, 0, 1, 32'h99999999, 0, 3,  1'b1, 32'h99999999};
    tbl[8] = '{3'b100, 1'b0, 0, 9, 32'hEEEEEEEE, 2, 10, 1'b1, 32'h00000000};

    for (int v = 0; v < 9; v++) begin
      for (int i = 0; i < NR; i++) begin
        if (tbl[v].mask[i]) f_we[i] = tbl[v].we;
      end
      req = tbl[v].mask;
      serve($sformatf("vec%0d", v), tbl[v].rdy, tbl[v].rsp, {32{tbl[v].word}},
            tbl[v].ew, tbl[v].elat, tbl[v].eerr, {32{tbl[v].erd}});
      req = '0;
    end

    // err_clear alone clears the sticky flag.
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("err_clear", timeout_err, 0);

    // err_clear held through a timeout: the set wins on its cycle.
    f_we[REQ_A] = 1'b0;
    req = 3'b001;
    err_clear = 1'b1;
    serve("clr_vs_set", 0, 0, rand_data(), 0, 2 + TMO, 1'b1, '0);
    chk("clr_after_set", timeout_err, 0);
    err_clear = 1'b0;

    dat = rand_data();
    f_we[REQ_B] = 1'b0;
    req = 3'b010;
    serve("pre_rst", 0, 1, dat, 1, 3, 1'b0, dat);

    // Reset while waiting for a read response; the late response is ignored.
    f_we[REQ_A]   = 1'b0;
    f_addr[REQ_A] = 32'hDEAD0000;
    req = 3'b001;
    for (int k = 0; k < 10 && !xbox_req_valid; k++) tick();
    chk("rst.reach_issue", xbox_req_valid, 1);
    xbox_req_ready = 1'b1;
    tick();
    xbox_req_ready = 1'b0;
    chk("rst.in_wait", {busy, xbox_req_valid}, 2'b10);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst.outs", {gnt, done, busy, xbox_req_valid, timeout_err, xbox_we}, 0);
    chk("rst.addr", xbox_addr, 0);
    chkw("rst.rd", rd_data, '0);
    req = '0;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      xbox_rsp_valid = 1'b1;
      xbox_rsp_data  = rand_data();
      tick();
      chk($sformatf("stray%0d.ctl", k), {gnt, done, busy}, 0);
      chkw($sformatf("stray%0d.rd", k), rd_data, '0);
    end
    xbox_rsp_valid = 1'b0;

    // Grant order with 111 held, then 101 re-raised.
    order = '{0, 1, 2, 0, 2};
    for (int i = 0; i < NR; i++) f_we[i] = 1'b1;
    req = 3'b111;
    for (int k = 0; k < 5; k++) begin
      if (k == 3) req = 3'b101;
      serve($sformatf("order%0d", k), 0, 0, rand_data(), order[k], 2, 1'b0, '0);
    end

    // Randomized traffic against the transaction model.
    m_ptr = 0;
    m_err = 1'b0;
    m_rd  = '0;
    for (int t = 0; t < 40; t++) begin
      int w, rdy, rsp, lat;
      logic tmo, clr, eerr;
      logic [DW-1:0] erd;
      for (int i = 0; i < NR; i++) begin
        if (!req[i] && ($urandom_range(0, 1) == 1)) begin
          f_we[i]    = 1'($urandom_range(0, 1));
          f_addr[i]  = $urandom;
          f_wdata[i] = rand_data();
          req[i]     = 1'b1;
        end
      end
      if (req == '0) begin
        w = $urandom_range(0, NR - 1);
        f_we[w] = 1'b0;
        f_addr[w] = $urandom;
        req[w] = 1'b1;
      end
      w = -1;
      for (int j = 0; j < NR; j++) begin
        if (w < 0 && req[(m_ptr + j) % NR]) w = (m_ptr + j) % NR;
      end
      rdy = $urandom_range(0, 3);
      rsp = $urandom_range(0, 10);
      dat = rand_data();
      clr = ($urandom_range(0, 3) == 0);
      tmo = !f_we[w] && (rsp == 0 || rsp > TMO);
      lat = 2 + rdy + (f_we[w] ? 0 : (tmo ? TMO : rsp));
      eerr = clr ? tmo : (m_err | tmo);
      erd  = f_we[w] ? m_rd : (tmo ? '0 : dat);
      err_clear = clr;
      serve($sformatf("rnd%0d", t), rdy, rsp, dat, w, lat, eerr, erd);
      err_clear = 1'b0;
      m_err = clr ? 1'b0 : eerr;
      m_rd  = erd;
      m_ptr = (w + 1) % NR;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tpum_xbox_port_arbiter.md
Name: tpum_xbox_port_arbiter

Overview:
- Shares the single XBOX memory port between the TPUM requesters: operand-A loader (R1), operand-B loader (R2) and result-C writer.
- Round-robin arbitration; one transaction outstanding at a time.
- Routes read data back to the winning requester.
- Response watchdog with sticky error flag.
- Sits between the TPUM control FSM / operand registers and the XBOX interface.

Parameters:
- NUM_REQ, 3, number of requesters (index 0=A, 1=B, 2=C).
- ADDR_W, 32, XBOX address width.
- DATA_W, 1024, XBOX data width (one R1/R2 register row).
- TIMEOUT, 255, max cycles waited for a read response; legal range 1..2^16-1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- req  in  NUM_REQ  per-requester transaction request.
- req_we  in  NUM_REQ  1=write, 0=read.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data.
- gnt  out  NUM_REQ  one-hot; owner of the current transaction.
- done  out  NUM_REQ  one-cycle completion pulse to owner.
- rd_data  out  DATA_W  captured read data; valid while done is high.
- busy  out  1  state != IDLE.
- timeout_err  out  1  sticky watchdog error.
- err_clear  in  1  clears timeout_err.
- xbox_req_valid  out  1  request to XBOX.
- xbox_req_ready  in  1  XBOX accepts request.
- xbox_we  out  1  request type.
- xbox_addr  out  ADDR_W  request address.
- xbox_wdata  out  DATA_W  write data.
- xbox_rsp_valid  in  1  read response valid.
- xbox_rsp_data  in  DATA_W  read response data.

Behaviour:
- Reset (async, rst=1): every output 0; state=IDLE; rr_ptr=0; owner, latched fields and timer cleared. A reset mid-transaction abandons it; XBOX responses arriving afterwards are ignored.
- States: IDLE, ISSUE, WAIT_RSP, DONE.
- IDLE, arbitration:
  - If any req bit is set, select the winner by scanning from rr_ptr upward, mod NUM_REQ.
  - Latch winner index, req_we, req_addr and req_wdata; go to ISSUE.
  - gnt[winner] rises at the next edge and stays high through DONE.
- ISSUE, request phase:
  - xbox_req_valid=1 with latched we/addr/wdata; these fields stay stable until handshake (valid & ready).
  - Write handshake -> DONE.
  - Read handshake -> WAIT_RSP, timer cleared to 0.
- WAIT_RSP, response phase:
  - xbox_req_valid=0; timer increments each cycle.
  - xbox_rsp_valid -> capture xbox_rsp_data into rd_data; go to DONE.
  - Timer reaches TIMEOUT-1 with no response -> set timeout_err; rd_data=0; go to DONE.
  - If the response and the timeout land on the same cycle, the response wins and no error is set.
- DONE, completion:
  - done[owner]=1 for exactly one cycle; then IDLE, gnt cleared, rr_ptr=(owner+1) mod NUM_REQ.
- Latency, XBOX ready immediately: write takes 3 cycles req->done; read takes 3 cycles plus response delay.
- Requester contract:
  - Hold req and inputs stable until done.
  - Deassert req on the edge after done, unless a further transaction is wanted.
  - Dropping req mid-transaction is ignored; the transaction completes.
- Stray xbox_rsp_valid in IDLE, ISSUE or DONE is ignored.
- err_clear clears timeout_err; a simultaneous set wins over clear.
- Only one transaction is in flight; there is no pipelining across requesters.

Decomposition:
- tpum_pkg holds:
  - the xbox_arb_state_t enum (one-hot: IDLE, ISSUE, WAIT_RSP, DONE);
  - constants REQ_A=0, REQ_B=1, REQ_C=2.
- Sub-module tpum_rr_pick: combinational round-robin selector. Inputs req and rr_ptr; outputs one-hot winner and winner index.

Test Plan:
- A read, addr 0x100, ready at once, rsp 2 cycles later with data 0xA5..A5 -> xbox_addr=0x100 and we=0; done[0] pulses once; rd_data=0xA5..A5; gnt returns to 0.
- req=3'b111 held after reset -> grant order 0,1,2. Then re-raise req=3'b101 after C completes -> order 0, then 2.
- C write, wdata=0x1234, xbox_req_ready low for 5 cycles -> valid, addr and wdata stable all 5 cycles; done[2] one cycle after handshake; no WAIT_RSP visited.
- TIMEOUT=8, read with no response -> timeout_err set 8 cycles after handshake; done[0] pulses with rd_data=0. err_clear=1 clears it; clear plus a new timeout in the same cycle -> stays 1.
- Reset asserted in WAIT_RSP, late rsp arrives afterwards -> all outputs 0 immediately; rsp ignored; no done pulse.
- Stray xbox_rsp_valid in IDLE -> no done, rd_data unchanged (0).
